// File: rtl/fifo_dict_multi.sv
// fifo_dict_multi: multi-entry compression dictionary FIFO.
// Packs a stream of DATA_WIDTH-bit words into WORDS_PER_ENTRY-word entries,
// held in a NUM_ENTRIES-slot circular buffer. Any slot can be read through a
// registered random-access port.
// Optional build macro FIFO_DICT_NO_OVERWRITE_EN: when defined, a full
// dictionary freezes at an entry boundary instead of replacing the oldest slot.
module fifo_dict_multi #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_ENTRY = 16,
  parameter int NUM_ENTRIES     = 4,
  localparam int ENTRY_WIDTH    = DATA_WIDTH * WORDS_PER_ENTRY,
  localparam int IDXW           = $clog2(NUM_ENTRIES),
  localparam int WCW            = $clog2(WORDS_PER_ENTRY),
  localparam int CNTW           = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [DATA_WIDTH-1:0]  w_data,
  input  logic                   flush,
  input  logic [IDXW-1:0]        rd_idx,
  output logic [ENTRY_WIDTH-1:0] r_data,
  output logic                   r_valid,
  output logic [IDXW-1:0]        wr_entry,
  output logic [WCW-1:0]         word_cnt,
  output logic [CNTW-1:0]        count,
  output logic                   full,
  output logic                   entry_done
);

  logic [WORDS_PER_ENTRY-1:0][DATA_WIDTH-1:0] r_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  r_slot_valid;
  logic [IDXW-1:0]         r_wr_entry;
  logic [WCW-1:0]          r_word_cnt;
  logic [CNTW-1:0]         r_count;
  logic                    r_full;
  logic                    r_entry_done;
  logic [ENTRY_WIDTH-1:0]  r_rdata;
  logic                    r_rvalid;

  logic                    w_first;
  logic                    w_last;
  logic                    w_block;
  logic                    w_accept;
  logic                    w_evict;
  logic [CNTW-1:0]         w_count_nxt;

  assign w_first = (r_word_cnt == '0);
  assign w_last  = (r_word_cnt == WCW'(WORDS_PER_ENTRY - 1));

`ifdef FIFO_DICT_NO_OVERWRITE_EN
  // A full dictionary refuses to start a new entry, so nothing is evicted.
  assign w_block = r_full && w_first;
`else
  assign w_block = 1'b0;
`endif

  // flush wins over wr; reset priority is applied inside the registers.
  assign w_accept = wr && !flush && !w_block;
  // Starting a new entry on a valid slot retires that slot immediately.
  assign w_evict  = w_accept && w_first && r_slot_valid[r_wr_entry];

  // Next occupancy: eviction and completion never coincide (entries have >= 2 words).
  always_comb begin
    w_count_nxt = r_count;
    if (w_evict)
      w_count_nxt = r_count - CNTW'(1);
    else if (w_accept && w_last)
      w_count_nxt = r_count + CNTW'(1);
  end

  // Entry storage: word write only, never cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!reset && w_accept)
      r_mem[r_wr_entry][r_word_cnt] <= w_data;
  end

  // Control state, status flags and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_wr_entry   <= '0;
      r_word_cnt   <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_entry_done <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      // Non-blocking read sees pre-write contents for a same-slot write.
      r_rdata  <= r_mem[rd_idx];
      r_rvalid <= r_slot_valid[rd_idx];
      if (flush) begin
        r_slot_valid <= '0;
        r_wr_entry   <= '0;
        r_word_cnt   <= '0;
        r_count      <= '0;
        r_full       <= 1'b0;
        r_entry_done <= 1'b0;
      end else begin
        r_entry_done <= w_accept && w_last;
        r_count      <= w_count_nxt;
        r_full       <= (w_count_nxt == CNTW'(NUM_ENTRIES));
        if (w_accept) begin
          r_word_cnt <= r_word_cnt + WCW'(1);
          if (w_evict)
            r_slot_valid[r_wr_entry] <= 1'b0;
          if (w_last) begin
            r_slot_valid[r_wr_entry] <= 1'b1;
            r_wr_entry               <= r_wr_entry + IDXW'(1);
          end
        end
      end
    end
  end

  assign r_data     = r_rdata;
  assign r_valid    = r_rvalid;
  assign wr_entry   = r_wr_entry;
  assign word_cnt   = r_word_cnt;
  assign count      = r_count;
  assign full       = r_full;
  assign entry_done = r_entry_done;

endmodule

// File: tb/tb_fifo_dict_multi.sv
// tb_fifo_dict_multi: scoreboard bench for fifo_dict_multi.
// Stimulus queues expected read-port and status values; a monitor on the
// falling edge pops and compares them.
`timescale 1ns/1ps
module tb_fifo_dict_multi;
  localparam int DW   = 32;
  localparam int WPE  = 16;
  localparam int NE   = 4;
  localparam int EW   = DW * WPE;
  localparam int IDXW = 2;
  localparam int WCW  = 4;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr;
  logic            flush;
  logic [DW-1:0]   w_data;
  logic [IDXW-1:0] rd_idx;
  logic [EW-1:0]   r_data;
  logic            r_valid;
  logic [IDXW-1:0] wr_entry;
  logic [WCW-1:0]  word_cnt;
  logic [CNTW-1:0] count;
  logic            full;
  logic            entry_done;

  fifo_dict_multi #(
    .DATA_WIDTH(DW),
    .WORDS_PER_ENTRY(WPE),
    .NUM_ENTRIES(NE)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .flush(flush),
    .rd_idx(rd_idx), .r_data(r_data), .r_valid(r_valid), .wr_entry(wr_entry),
    .word_cnt(word_cnt), .count(count), .full(full), .entry_done(entry_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            v;
    bit            cd;
    logic [EW-1:0] d;
  } rd_exp_t;

  typedef struct {
    string name;
    int    we, wc, cnt, fl, ed, dn;
  } st_exp_t;

  rd_exp_t rq[$];
  st_exp_t sq[$];
  int errors    = 0;
  int checks    = 0;
  int done_seen = 0;
  int ed_total  = 0;
  bit rd_req    = 1'b0;
  bit st_req    = 1'b0;
  bit rd_pend   = 1'b0;

  function automatic void chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [EW-1:0] mk(input int unsigned base);
    logic [EW-1:0] m;
    m = '0;
    for (int unsigned j = 0; j < WPE; j++)
      m[j*DW +: DW] = DW'(base + j);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    wr     = 1'b0;
    flush  = 1'b0;
    rd_req = 1'b0;
    st_req = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d);
    wr     = 1'b1;
    w_data = d;
    tick();
  endtask

  task automatic put_entry(input int unsigned base);
    for (int unsigned j = 0; j < WPE; j++)
      put(DW'(base + j));
  endtask

  task automatic exp_st(input string n, input int we, input int wc, input int cnt, input int fl, input int ed);
    st_exp_t s;
    s.name = n; s.we = we; s.wc = wc; s.cnt = cnt; s.fl = fl; s.ed = ed; s.dn = ed_total;
    sq.push_back(s);
    st_req = 1'b1;
  endtask

  task automatic exp_rd(input string n, input int idx, input bit v, input bit cd, input logic [EW-1:0] d);
    rd_exp_t r;
    r.name = n; r.v = v; r.cd = cd; r.d = d;
    rq.push_back(r);
    rd_idx = IDXW'(idx);
    rd_req = 1'b1;
  endtask

  // Read results appear one edge after the request.
  always @(posedge clk) rd_pend <= rd_req;

  // Monitor: count entry_done pulses, then compare whatever is due this cycle.
  always @(negedge clk) begin
    rd_exp_t r;
    st_exp_t s;
    if (entry_done === 1'b1) done_seen++;
    if (rd_pend) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_queue: got empty queue expected an entry");
      end else begin
        r = rq.pop_front();
        chk({r.name, "_rvalid"}, EW'(r_valid), EW'(r.v));
        if (r.cd) chk({r.name, "_rdata"}, r_data, r.d);
      end
    end
    if (st_req) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue: got empty queue expected an entry");
      end else begin
        s = sq.pop_front();
        chk({s.name, "_wr_entry"},   EW'(wr_entry),   EW'(s.we));
        chk({s.name, "_word_cnt"},   EW'(word_cnt),   EW'(s.wc));
        chk({s.name, "_count"},      EW'(count),      EW'(s.cnt));
        chk({s.name, "_full"},       EW'(full),       EW'(s.fl));
        chk({s.name, "_entry_done"}, EW'(entry_done), EW'(s.ed));
        chk({s.name, "_done_pulses"}, EW'(done_seen), EW'(s.dn));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [EW-1:0] e;
    reset = 1'b1; wr = 1'b0; flush = 1'b0; w_data = '0; rd_idx = '0;
    exp_rd("rst_read", 0, 1'b0, 1'b1, '0);
    tick();
    tick();
    reset = 1'b0;
    exp_st("reset", 0, 0, 0, 0, 0);

    // First entry: words 0..15 into slot 0.
    put_entry(0);
    ed_total = 1;
    exp_st("e0_done", 1, 0, 1, 0, 1);
    exp_rd("e0_read", 0, 1'b1, 1'b1, mk(0));
    tick();
    exp_st("e0_pulse_end", 1, 0, 1, 0, 0);

    // Fill the rest; read slot 2 on the cycle its last word is written.
    for (int unsigned j = 16; j < 47; j++) put(DW'(j));
    exp_rd("s2_same_cycle", 2, 1'b0, 1'b0, '0);
    put(DW'(47));
    exp_rd("s2_next_cycle", 2, 1'b1, 1'b1, mk(32));
    for (int unsigned j = 48; j < 64; j++) put(DW'(j));
    ed_total = 4;
    exp_st("full", 0, 0, 4, 1, 1);
    for (int k = 0; k < NE; k++) begin
      exp_rd($sformatf("full_slot%0d", k), k, 1'b1, 1'b1, mk(16 * k));
      tick();
    end
    exp_st("full_idle", 0, 0, 4, 1, 0);

`ifdef FIFO_DICT_NO_OVERWRITE_EN
    put(DW'(32'h100));
    exp_st("frz_first", 0, 0, 4, 1, 0);
    for (int unsigned j = 1; j < 16; j++) put(DW'(32'h100 + j));
    exp_st("frz_done", 0, 0, 4, 1, 0);
    exp_rd("frz_slot0", 0, 1'b1, 1'b1, mk(0));
    tick();
`else
    put(DW'(32'h100));
    exp_st("ovw_first", 0, 1, 3, 0, 0);
    e = mk(0);
    e[DW-1:0] = DW'(32'h100);
    exp_rd("ovw_invalid", 0, 1'b0, 1'b1, e);
    for (int unsigned j = 1; j < 16; j++) put(DW'(32'h100 + j));
    ed_total = 5;
    exp_st("ovw_done", 1, 0, 4, 1, 1);
    exp_rd("ovw_slot0", 0, 1'b1, 1'b1, mk(32'h100));
    tick();
    put_entry(32'h110);
    ed_total = 6;
    for (int unsigned j = 0; j < 15; j++) put(DW'(32'h120 + j));
    // Pre-write contents: new words 0..14, stale word 15 from the first pass.
    e = mk(32'h120);
    e[15*DW +: DW] = DW'(47);
    exp_rd("s2_old_data", 2, 1'b0, 1'b1, e);
    put(DW'(32'h12F));
    ed_total = 7;
    exp_st("s2_done", 3, 0, 4, 1, 1);
    exp_rd("s2_new_data", 2, 1'b1, 1'b1, mk(32'h120));
    tick();
`endif

    // Flush alone, then flush colliding with the 8th word of an entry.
    flush = 1'b1;
    tick();
    exp_st("flush", 0, 0, 0, 0, 0);
    for (int unsigned j = 0; j < 7; j++) put(DW'(32'h200 + j));
    exp_st("pre_flush", 0, 7, 0, 0, 0);
    wr = 1'b1; w_data = DW'(32'h207); flush = 1'b1;
    tick();
    exp_st("flush_wr", 0, 0, 0, 0, 0);
`ifdef FIFO_DICT_NO_OVERWRITE_EN
    e = mk(0);
`else
    e = mk(32'h100);
`endif
    for (int unsigned j = 0; j < 7; j++) e[j*DW +: DW] = DW'(32'h200 + j);
    exp_rd("flush_slot0", 0, 1'b0, 1'b1, e);
    tick();
    for (int k = 1; k < NE; k++) begin
      exp_rd($sformatf("flush_slot%0d", k), k, 1'b0, 1'b0, '0);
      tick();
    end

    // Reset in the middle of an entry with two complete slots.
    put_entry(32'h300);
    put_entry(32'h310);
    ed_total = ed_total + 2;
    for (int unsigned j = 0; j < 9; j++) put(DW'(32'h320 + j));
    exp_st("pre_reset", 2, 9, 2, 0, 0);
    exp_rd("pre_reset_rd", 0, 1'b1, 1'b1, mk(32'h300));
    tick();
    reset = 1'b1;
    exp_rd("reset_mid_rd", 0, 1'b0, 1'b1, '0);
    tick();
    reset = 1'b0;
    exp_st("reset_mid", 0, 0, 0, 0, 0);
    put(DW'(32'h400));
    exp_st("post_reset", 0, 1, 0, 0, 0);
    e = mk(32'h300);
    e[DW-1:0] = DW'(32'h400);
    exp_rd("post_reset_rd", 0, 1'b0, 1'b1, e);
    tick();
    tick();
    tick();

    checks++;
    if (rq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", rq.size() + sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
